// File: rtl/serial_receiver.sv
// 8N1 UART receiver with 16x oversampling; byte is valid the cycle after the stop-bit sample tick.
// No backpressure: an unacknowledged byte is kept and later bytes are dropped with an overrun pulse.
module serial_receiver #(
  parameter int SAMPLE_DIV = 163
) (
  input  logic       IN_clk,
  input  logic       IN_rst,
  input  logic       IN_rx,
  input  logic       IN_ack,
  output logic [7:0] OUT_data,
  output logic       OUT_valid,
  output logic       OUT_frame_err,
  output logic       OUT_overrun
);

  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(SAMPLE_DIV - 1);

  if (SAMPLE_DIV < 2) begin : g_bad_div
    $error("serial_receiver: SAMPLE_DIV must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] tick_cnt;
  logic [3:0]    sub_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick;

  assign tick = (tick_cnt == TICK_MAX);

  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      state         <= S_IDLE;
      tick_cnt      <= '0;
      sub_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      OUT_data      <= 8'h00;
      OUT_valid     <= 1'b0;
      OUT_frame_err <= 1'b0;
      OUT_overrun   <= 1'b0;
    end else begin
      rx_meta       <= IN_rx;
      rx_s          <= rx_meta;
      OUT_frame_err <= 1'b0;
      OUT_overrun   <= 1'b0;

      if (IN_ack) begin
        OUT_valid <= 1'b0;
      end

      // Counters only run while a frame is in flight, so START always begins at zero.
      if (state == S_IDLE || state == S_BREAK) begin
        tick_cnt <= '0;
        sub_cnt  <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) begin
          sub_cnt <= sub_cnt + 4'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state   <= S_START;
            bit_cnt <= '0;
          end
        end

        S_START: begin
          if (tick && sub_cnt == 4'd7) begin
            if (!rx_s) begin
              state   <= S_DATA;
              sub_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_DATA: begin
          if (tick && sub_cnt == 4'd15) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
            end
          end
        end

        S_STOP: begin
          if (tick && sub_cnt == 4'd15) begin
            if (rx_s) begin
              state <= S_IDLE;
              // A same-cycle ack frees the holding register, so the new byte takes it.
              if (!OUT_valid || IN_ack) begin
                OUT_data  <= shreg;
                OUT_valid <= 1'b1;
              end else begin
                OUT_overrun <= 1'b1;
              end
            end else begin
              OUT_frame_err <= 1'b1;
              state         <= S_BREAK;
            end
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Scenario bench for serial_receiver at SAMPLE_DIV=4 (64-cycle bit time).
module tb_serial_receiver;

  logic       IN_clk = 1'b0;
  logic       IN_rst = 1'b1;
  logic       IN_rx  = 1'b1;
  logic       IN_ack = 1'b0;
  logic [7:0] OUT_data;
  logic       OUT_valid;
  logic       OUT_frame_err;
  logic       OUT_overrun;

  serial_receiver #(.SAMPLE_DIV(4)) dut (
    .IN_clk       (IN_clk),
    .IN_rst       (IN_rst),
    .IN_rx        (IN_rx),
    .IN_ack       (IN_ack),
    .OUT_data     (OUT_data),
    .OUT_valid    (OUT_valid),
    .OUT_frame_err(OUT_frame_err),
    .OUT_overrun  (OUT_overrun)
  );

  always #5 IN_clk = ~IN_clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int ovr_cyc = 0;
  int data_chg = 0;
  logic prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_q[$];

  always @(posedge IN_clk) cyc <= cyc + 1;

  // Event monitor, sampled 2ns after each rising edge.
  always @(posedge IN_clk) begin
    #2;
    if (OUT_valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    prev_valid = OUT_valid;
    if (OUT_frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (OUT_overrun === 1'b1) begin
      ovr_cnt = ovr_cnt + 1;
      ovr_cyc = cyc;
    end
    if (OUT_data !== prev_data) data_chg = data_chg + 1;
    prev_data = OUT_data;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bt, output int t0);
    @(negedge IN_clk);
    t0 = cyc;
    IN_rx = 1'b0;
    repeat (bt) @(negedge IN_clk);
    for (int i = 0; i < 8; i++) begin
      IN_rx = b[i];
      repeat (bt) @(negedge IN_clk);
    end
    IN_rx = stop;
    repeat (bt) @(negedge IN_clk);
  endtask

  task automatic do_ack();
    @(negedge IN_clk);
    IN_ack = 1'b1;
    @(negedge IN_clk);
    IN_ack = 1'b0;
    @(negedge IN_clk);
  endtask

  task automatic test_reset();
    IN_rst = 1'b1;
    repeat (3) @(negedge IN_clk);
    nvec++; if (OUT_data !== 8'h00) begin nerr++; $display("FAIL reset_data got=%h exp=00", OUT_data); end
    nvec++; if (OUT_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", OUT_valid); end
    nvec++; if (OUT_frame_err !== 1'b0) begin nerr++; $display("FAIL reset_ferr got=%b exp=0", OUT_frame_err); end
    nvec++; if (OUT_overrun !== 1'b0) begin nerr++; $display("FAIL reset_ovr got=%b exp=0", OUT_overrun); end
    IN_rst = 1'b0;
    repeat (5) @(negedge IN_clk);
  endtask

  task automatic test_basic();
    int t0, r0, f0, o0;
    logic [7:0] e;
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 64, t0);
    nvec++; if (rise_cnt - r0 !== 1) begin nerr++; $display("FAIL basic_rise got=%0d exp=1", rise_cnt - r0); end
    e = exp_q.pop_front();
    nvec++; if (OUT_data !== e) begin nerr++; $display("FAIL basic_data got=%h exp=%h", OUT_data, e); end
    // Stop-bit centre is 9.5 bits (608 cycles) after the falling edge, plus synchronizer and output latency.
    nvec++; if (rise_cyc - t0 < 608 || rise_cyc - t0 > 613) begin nerr++; $display("FAIL basic_latency got=%0d exp=608..613", rise_cyc - t0); end
    nvec++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin nerr++; $display("FAIL basic_err_pulses got=%0d exp=0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
    do_ack();
    nvec++; if (OUT_valid !== 1'b0) begin nerr++; $display("FAIL basic_ack got=%b exp=0", OUT_valid); end
  endtask

  task automatic test_overrun();
    int t0, r0, o0;
    logic [7:0] e;
    r0 = rise_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 64, t0);
    e = exp_q.pop_front();
    nvec++; if (OUT_data !== e) begin nerr++; $display("FAIL ovr_first_data got=%h exp=%h", OUT_data, e); end
    o0 = ovr_cnt;
    send_frame(8'h81, 1'b1, 64, t0);
    repeat (4) @(negedge IN_clk);
    nvec++; if (ovr_cnt - o0 !== 1) begin nerr++; $display("FAIL ovr_count got=%0d exp=1", ovr_cnt - o0); end
    nvec++; if (ovr_cyc - t0 < 608 || ovr_cyc - t0 > 613) begin nerr++; $display("FAIL ovr_timing got=%0d exp=608..613", ovr_cyc - t0); end
    nvec++; if (OUT_data !== 8'h3C) begin nerr++; $display("FAIL ovr_data_kept got=%h exp=3c", OUT_data); end
    nvec++; if (OUT_valid !== 1'b1) begin nerr++; $display("FAIL ovr_valid got=%b exp=1", OUT_valid); end
    nvec++; if (rise_cnt - r0 !== 1) begin nerr++; $display("FAIL ovr_rises got=%0d exp=1", rise_cnt - r0); end
  endtask

  // Ack lands on the delivery edge: the new byte must replace the old one with no overrun.
  task automatic test_ack_collision();
    int t0, t1, o0;
    logic [7:0] e;
    o0 = ovr_cnt;
    exp_q.push_back(8'h96);
    fork
      send_frame(8'h96, 1'b1, 64, t0);
      begin
        @(negedge IN_clk);
        t1 = cyc;
        while (cyc < t1 + 610) @(negedge IN_clk);
        IN_ack = 1'b1;
        @(negedge IN_clk);
        IN_ack = 1'b0;
      end
    join
    e = exp_q.pop_front();
    nvec++; if (OUT_data !== e) begin nerr++; $display("FAIL coll_data got=%h exp=%h", OUT_data, e); end
    nvec++; if (OUT_valid !== 1'b1) begin nerr++; $display("FAIL coll_valid got=%b exp=1", OUT_valid); end
    nvec++; if (ovr_cnt - o0 !== 0) begin nerr++; $display("FAIL coll_ovr got=%0d exp=0", ovr_cnt - o0); end
  endtask

  task automatic test_reset_midframe();
    int t0, r0, f0, o0, d0;
    logic [7:0] e;
    @(negedge IN_clk);
    IN_rx = 1'b0;
    repeat (64 + 4 * 64 + 32) @(negedge IN_clk);
    IN_rst = 1'b1;
    IN_rx = 1'b1;
    repeat (2) @(negedge IN_clk);
    nvec++; if (OUT_data !== 8'h00) begin nerr++; $display("FAIL midrst_data got=%h exp=00", OUT_data); end
    nvec++; if (OUT_valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid got=%b exp=0", OUT_valid); end
    IN_rst = 1'b0;
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt; d0 = data_chg;
    repeat (700) @(negedge IN_clk);
    nvec++; if ((rise_cnt - r0) + (ferr_cnt - f0) + (ovr_cnt - o0) + (data_chg - d0) !== 0) begin
      nerr++; $display("FAIL midrst_quiet got=%0d events exp=0", (rise_cnt - r0) + (ferr_cnt - f0) + (ovr_cnt - o0) + (data_chg - d0));
    end
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 64, t0);
    e = exp_q.pop_front();
    nvec++; if (OUT_data !== e || OUT_valid !== 1'b1) begin nerr++; $display("FAIL midrst_next got=%h/%b exp=%h/1", OUT_data, OUT_valid, e); end
    do_ack();
  endtask

  task automatic test_frame_err();
    int t0, r0, f0;
    logic [7:0] e;
    r0 = rise_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 64, t0);
    repeat (200) @(negedge IN_clk);
    nvec++; if (ferr_cnt - f0 !== 1) begin nerr++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
    nvec++; if (OUT_valid !== 1'b0 || rise_cnt != r0) begin nerr++; $display("FAIL ferr_valid got=%b exp=0", OUT_valid); end
    IN_rx = 1'b1;
    repeat (20) @(negedge IN_clk);
    nvec++; if (ferr_cnt - f0 !== 1 || rise_cnt != r0) begin nerr++; $display("FAIL ferr_break_quiet got=%0d exp=1", ferr_cnt - f0); end
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 64, t0);
    e = exp_q.pop_front();
    nvec++; if (OUT_data !== e || OUT_valid !== 1'b1) begin nerr++; $display("FAIL ferr_next got=%h/%b exp=%h/1", OUT_data, OUT_valid, e); end
    do_ack();
  endtask

  task automatic test_glitch();
    int r0, f0, o0, d0;
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt; d0 = data_chg;
    @(negedge IN_clk);
    IN_rx = 1'b0;
    repeat (20) @(negedge IN_clk);
    IN_rx = 1'b1;
    repeat (100) @(negedge IN_clk);
    nvec++; if ((rise_cnt - r0) + (ferr_cnt - f0) + (ovr_cnt - o0) + (data_chg - d0) !== 0) begin
      nerr++; $display("FAIL glitch_quiet got=%0d events exp=0", (rise_cnt - r0) + (ferr_cnt - f0) + (ovr_cnt - o0) + (data_chg - d0));
    end
    nvec++; if (OUT_valid !== 1'b0) begin nerr++; $display("FAIL glitch_valid got=%b exp=0", OUT_valid); end
  endtask

  task automatic test_baud_tol();
    int t0, r0;
    int bts[2] = '{62, 66};
    logic [7:0] e;
    foreach (bts[k]) begin
      r0 = rise_cnt;
      exp_q.push_back(8'h69);
      send_frame(8'h69, 1'b1, bts[k], t0);
      repeat (2) @(negedge IN_clk);
      e = exp_q.pop_front();
      nvec++; if (rise_cnt - r0 !== 1 || OUT_data !== e) begin
        nerr++; $display("FAIL baud_%0d got=%h rises=%0d exp=%h rises=1", bts[k], OUT_data, rise_cnt - r0, e);
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_ack_collision();
    test_reset_midframe();
    test_frame_err();
    test_glitch();
    test_baud_tol();
    nvec++; if (exp_q.size() !== 0) begin nerr++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
